uart_rx_framed: RTL
===================

// Module: uart_rx_framed
// PURPOSE
//  Parametrised UART receiver, next generation of the instruction receiver. Samples rx mid-bit.
//  Validates the start bit; checks optional parity and 1/2 stop bits.
//  Delivers each word on a valid/ready handshake with frame, parity and overrun status.
//  Sits between the rx pad (ui_in) and instruction/transmit logic.
// PARAMETERS
//  DATA_BITS   8    word width, 5..16, LSB received first
//  BAUD_DIV    434  clk cycles per bit, >=4; BAUD_DIV/2 uses integer division
//  PARITY_EN   0    1 = one parity bit follows the data
//  PARITY_ODD  0    1 = odd parity, 0 = even (only when PARITY_EN=1)
//  STOP_BITS   1    1 or 2
// PORTS
//  clk         in   1          single clock; all logic on its rising edge
//  reset       in   1          synchronous, active-high
//  rx          in   1          async serial line, idle high
//  rx_data     out  DATA_BITS  received word, stable while rx_valid=1
//  rx_valid    out  1          word available; held until accepted
//  rx_ready    in   1          consumer accepts on cycle where rx_valid&rx_ready
//  frame_err   out  1          qualifies rx_data: a stop bit sampled 0
//  parity_err  out  1          qualifies rx_data: parity mismatch (0 if PARITY_EN=0)
//  overrun     out  1          an unaccepted word was overwritten; cleared on acceptance
//  busy        out  1          FSM not in IDLE
// BEHAVIOUR
//  Reset: rx_data=0, rx_valid=0, frame_err=0, parity_err=0, overrun=0, busy=0.
//   State=IDLE; 2-flop rx synchroniser=1; armed=0. Reset mid-frame discards the frame.
//  Synchroniser: rx_s = rx delayed 2 clk; all decisions use rx_s only.
//  armed: set when rx_s=1 in IDLE; a start needs armed=1.
//   A line held low through reset or a break never starts a frame.
//  FSM IDLE->START->DATA->[PARITY]->STOP->IDLE. Baud counter reloads on each transition.
//  IDLE:   rx_s=0 & armed -> START, counter=0, busy=1 next cycle.
//  START:  sample at counter=BAUD_DIV/2-1.
//          rx_s=1 -> IDLE (glitch, no output). rx_s=0 -> DATA.
//  DATA:   sample every BAUD_DIV cycles; shift right (bit0 first).
//          After DATA_BITS samples -> PARITY if PARITY_EN, else STOP.
//  PARITY: one sample; parity_err_n = (^data ^ rx_s) != PARITY_ODD.
//  STOP:   STOP_BITS samples; any 0 sets frame_err_n.
//          After the last sample -> IDLE and load output regs on the same edge.
//          IDLE is entered at mid stop bit, so back-to-back frames are caught.
//  Break: frame_err_n=1, data=0 is delivered, armed=0 until rx_s returns high.
//  Latency: rx_valid rises exactly 2 + BAUD_DIV/2 + (DATA_BITS+PARITY_EN+STOP_BITS)*BAUD_DIV
//   cycles after the rx pin falls (start edge aligned to clk).
//  Output load (frame completes): rx_data, frame_err, parity_err <= new values; rx_valid <= 1.
//   overrun <= 1 if rx_valid=1 and not accepted this cycle; otherwise overrun <= 0.
//  Accept without completion: rx_valid <= 0, overrun <= 0. Status bits persist until next load.
//  Completion in the same cycle as acceptance: normal load, rx_valid stays 1, overrun=0.
//  Widths: baud counter $clog2(BAUD_DIV) bits, wraps at BAUD_DIV-1.
//   Bit counter $clog2(DATA_BITS+2) bits. No arithmetic overflow is reachable.
// STRUCTURE
//  uart_pkg: FSM state localparams (IDLE/START/DATA/PARITY/STOP), parity function.
//   The transmitter shares it.
//  Sub-module uart_baud_tick: counter with half/full-period reload, one-cycle tick output.
//   Reused by the transmitter.
//  Synchroniser, FSM, shift register and output/handshake register live in this module.
// TESTING (BAUD_DIV=16 unless noted)
//  1. 8N1, send 0xA5, rx_ready=1 -> rx_valid 1 cycle, rx_data=0xA5, errs=0; valid at 2+8+9*16=154 cyc.
//  2. Start glitch: rx low 4 cycles -> no rx_valid, busy returns 0 by cycle 11.
//  3. PARITY_EN=1, PARITY_ODD=0, 0x07 with parity bit 0 -> rx_data=0x07, parity_err=1.
//  4. Stop bit driven 0 -> frame_err=1. Then rx low 30 bit-times -> one break word (0x00, frame_err), no restart until rx high.
//  5. rx_ready=0, send 0x11 then 0x22 -> rx_data=0x22, overrun=1; assert rx_ready -> valid=0, overrun=0.
//  6. DATA_BITS=12, STOP_BITS=2: 0xABC accepted; reset mid-DATA -> all outputs 0, next frame 0x123 correct.

Source files
------------

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - UART frame states and parity helper shared by receiver and transmitter
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } uart_state_t;

    // True when data parity combined with the parity bit disagrees with the selected sense.
    function automatic logic parity_mismatch(input logic data_xor, input logic par_bit,
                                             input logic odd);
        return (data_xor ^ par_bit) != odd;
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// rtl/uart_baud_tick.sv - baud counter with half/full-period reload and one-cycle tick
module uart_baud_tick #(
    parameter int BAUD_DIV = 434
) (
    input  logic clk,
    input  logic reset,
    input  logic reload,
    input  logic half,
    output logic tick
);

    localparam int CW = $clog2(BAUD_DIV);
    localparam logic [CW-1:0] HALF_LAST = CW'(BAUD_DIV / 2 - 1);
    localparam logic [CW-1:0] FULL_LAST = CW'(BAUD_DIV - 1);

    logic [CW-1:0] count;

    assign tick = (count == (half ? HALF_LAST : FULL_LAST));

    // Wrapping on tick restarts the period on every state change the tick causes.
    always_ff @(posedge clk) begin
        if (reset || reload) begin
            count <= '0;
        end else if (tick) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/uart_rx_framed.sv
// rtl/uart_rx_framed.sv - framed UART receiver with valid/ready output and error status
module uart_rx_framed
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = 8,
    parameter int BAUD_DIV   = 434,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 overrun,
    output logic                 busy
);

    localparam int BW = $clog2(DATA_BITS + 2);
    localparam logic [BW-1:0] LAST_DATA = BW'(DATA_BITS - 1);
    localparam logic [BW-1:0] LAST_STOP = BW'(STOP_BITS - 1);

    logic                 rx_m, rx_s, armed;
    uart_state_t          state, state_n;
    logic [BW-1:0]        bit_cnt, bit_cnt_n;
    logic [DATA_BITS-1:0] shift, shift_n;
    logic                 frame_acc, frame_acc_n;
    logic                 par_acc, par_acc_n;
    logic                 tick, load;

    uart_baud_tick #(.BAUD_DIV(BAUD_DIV)) u_baud (
        .clk    (clk),
        .reset  (reset),
        .reload (state == ST_IDLE),
        .half   (state == ST_START),
        .tick   (tick)
    );

    assign busy = (state != ST_IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
        end else begin
            rx_m <= rx;
            rx_s <= rx_m;
        end
    end

    // Disarmed on every start so a line stuck low after a break cannot retrigger.
    always_ff @(posedge clk) begin
        if (reset) begin
            armed <= 1'b0;
        end else if (state == ST_IDLE) begin
            if (rx_s)
                armed <= 1'b1;
            else if (armed)
                armed <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            bit_cnt   <= '0;
            shift     <= '0;
            frame_acc <= 1'b0;
            par_acc   <= 1'b0;
        end else begin
            state     <= state_n;
            bit_cnt   <= bit_cnt_n;
            shift     <= shift_n;
            frame_acc <= frame_acc_n;
            par_acc   <= par_acc_n;
        end
    end

    always_comb begin
        state_n     = state;
        bit_cnt_n   = bit_cnt;
        shift_n     = shift;
        frame_acc_n = frame_acc;
        par_acc_n   = par_acc;
        load        = 1'b0;
        case (state)
            ST_IDLE: begin
                bit_cnt_n   = '0;
                frame_acc_n = 1'b0;
                par_acc_n   = 1'b0;
                if (!rx_s && armed)
                    state_n = ST_START;
            end
            ST_START: begin
                if (tick)
                    state_n = rx_s ? ST_IDLE : ST_DATA;
            end
            ST_DATA: begin
                if (tick) begin
                    shift_n = {rx_s, shift[DATA_BITS-1:1]};
                    if (bit_cnt == LAST_DATA) begin
                        bit_cnt_n = '0;
                        state_n   = (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
                    end else begin
                        bit_cnt_n = bit_cnt + 1'b1;
                    end
                end
            end
            ST_PARITY: begin
                if (tick) begin
                    par_acc_n = (PARITY_EN != 0) && parity_mismatch(^shift, rx_s, PARITY_ODD != 0);
                    state_n   = ST_STOP;
                end
            end
            ST_STOP: begin
                if (tick) begin
                    if (!rx_s)
                        frame_acc_n = 1'b1;
                    if (bit_cnt == LAST_STOP) begin
                        state_n = ST_IDLE;
                        load    = 1'b1;
                    end else begin
                        bit_cnt_n = bit_cnt + 1'b1;
                    end
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    // A completing frame wins over acceptance; overrun flags a word lost without handshake.
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
            overrun    <= 1'b0;
        end else if (load) begin
            rx_data    <= shift;
            frame_err  <= frame_acc_n;
            parity_err <= par_acc;
            rx_valid   <= 1'b1;
            overrun    <= rx_valid && !rx_ready;
        end else if (rx_valid && rx_ready) begin
            rx_valid <= 1'b0;
            overrun  <= 1'b0;
        end
    end

endmodule
